// File: rtl/mgr_upstream_router.sv
// mgr_upstream_router
//   Routes packets from one upstream stream to NUM_CH consumer channels.
//   The low CH_W bits of the tag at start-of-message pick the channel. Each
//   channel has its own FIFO, so a stalled consumer only blocks the input
//   while the current beat targets it. Packets to a disabled or out-of-range
//   channel are dropped and counted. Delineator misuse sets a sticky error.
//
// Ports
//   clk, reset_poweron         clock, synchronous active-high reset
//   stu__rtr__valid/cntl/tag/data, rtr__stu__ready   upstream beat handshake
//   rtr__cns__valid/cntl/tag/data, cns__rtr__ready   per-channel outputs (packed, ch0 in LSBs)
//   cfg__rtr__ch_enable        per-channel enable, sampled at each SOM
//   cfg__rtr__err_clear        clears rtr__sys__proto_err
//   rtr__sys__proto_err        sticky protocol error
//   rtr__sys__drop_count       saturating dropped-packet count
module mgr_upstream_router #(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 64,
    parameter int TAG_W      = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_poweron,
    input  logic                     stu__rtr__valid,
    input  logic [1:0]               stu__rtr__cntl,
    output logic                     rtr__stu__ready,
    input  logic [TAG_W-1:0]         stu__rtr__tag,
    input  logic [DATA_W-1:0]        stu__rtr__data,
    output logic [NUM_CH-1:0]        rtr__cns__valid,
    output logic [2*NUM_CH-1:0]      rtr__cns__cntl,
    input  logic [NUM_CH-1:0]        cns__rtr__ready,
    output logic [TAG_W*NUM_CH-1:0]  rtr__cns__tag,
    output logic [DATA_W*NUM_CH-1:0] rtr__cns__data,
    input  logic [NUM_CH-1:0]        cfg__rtr__ch_enable,
    input  logic                     cfg__rtr__err_clear,
    output logic                     rtr__sys__proto_err,
    output logic [15:0]              rtr__sys__drop_count
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int ENT_W = 2 + TAG_W + DATA_W;

    localparam logic [1:0] C_SOM_EOM = 2'b00;
    localparam logic [1:0] C_SOM     = 2'b01;
    localparam logic [1:0] C_MOM     = 2'b10;
    localparam logic [1:0] C_EOM     = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_ROUTE, ST_DROP} state_t;

    state_t            state, state_nxt;
    logic [CH_W-1:0]   lat_ch, lat_ch_nxt;
    logic [TAG_W-1:0]  lat_tag;
    logic              tag_latch;

    logic [CH_W-1:0]   tag_ch;
    logic              tag_en;
    logic              full_tag, full_lat;
    logic [NUM_CH-1:0] full, empty, push, pop;

    logic              accept;
    logic              push_any;
    logic [CH_W-1:0]   push_ch;
    logic [1:0]        push_cntl;
    logic [TAG_W-1:0]  push_tag;
    logic              err_set, drop_inc;

    logic              proto_err_q;
    logic [15:0]       drop_q;

    assign tag_ch = stu__rtr__tag[CH_W-1:0];

    // Channel codes >= NUM_CH match no index and therefore read as disabled.
    always_comb begin
        tag_en   = 1'b0;
        full_tag = 1'b0;
        full_lat = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (tag_ch == CH_W'(i)) begin
                tag_en   = cfg__rtr__ch_enable[i];
                full_tag = full[i];
            end
            if (lat_ch == CH_W'(i)) begin
                full_lat = full[i];
            end
        end
    end

    // Ready looks only at registered fullness, never at valid, so a pop in
    // the same cycle does not open room for a push.
    always_comb begin
        rtr__stu__ready = 1'b1;
        if (reset_poweron) begin
            rtr__stu__ready = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if ((stu__rtr__cntl == C_SOM_EOM || stu__rtr__cntl == C_SOM) && tag_en) begin
                        rtr__stu__ready = !full_tag;
                    end
                end
                ST_ROUTE: rtr__stu__ready = !full_lat;
                default:  rtr__stu__ready = 1'b1;
            endcase
        end
    end

    assign accept = stu__rtr__valid && rtr__stu__ready;

    always_comb begin
        state_nxt  = state;
        lat_ch_nxt = lat_ch;
        tag_latch  = 1'b0;
        push_any   = 1'b0;
        push_ch    = lat_ch;
        push_cntl  = stu__rtr__cntl;
        push_tag   = lat_tag;
        err_set    = 1'b0;
        drop_inc   = 1'b0;
        if (accept) begin
            case (state)
                ST_IDLE: begin
                    case (stu__rtr__cntl)
                        C_SOM_EOM: begin
                            if (tag_en) begin
                                push_any = 1'b1;
                                push_ch  = tag_ch;
                                push_tag = stu__rtr__tag;
                            end else begin
                                drop_inc = 1'b1;
                            end
                        end
                        C_SOM: begin
                            lat_ch_nxt = tag_ch;
                            tag_latch  = 1'b1;
                            if (tag_en) begin
                                state_nxt = ST_ROUTE;
                                push_any  = 1'b1;
                                push_ch   = tag_ch;
                                push_tag  = stu__rtr__tag;
                            end else begin
                                state_nxt = ST_DROP;
                                drop_inc  = 1'b1;
                            end
                        end
                        default: err_set = 1'b1;
                    endcase
                end
                default: begin
                    // Inside a packet a stray SOM continues it and a stray
                    // SOM_EOM closes it; both are flagged.
                    if (stu__rtr__cntl == C_SOM) begin
                        push_cntl = C_MOM;
                        err_set   = 1'b1;
                    end
                    if (stu__rtr__cntl == C_SOM_EOM) begin
                        push_cntl = C_EOM;
                        err_set   = 1'b1;
                    end
                    push_any = (state == ST_ROUTE);
                    if (stu__rtr__cntl == C_EOM || stu__rtr__cntl == C_SOM_EOM) begin
                        state_nxt = ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            state       <= ST_IDLE;
            lat_ch      <= '0;
            proto_err_q <= 1'b0;
            drop_q      <= '0;
        end else begin
            state  <= state_nxt;
            lat_ch <= lat_ch_nxt;
            if (err_set) begin
                proto_err_q <= 1'b1;
            end else if (cfg__rtr__err_clear) begin
                proto_err_q <= 1'b0;
            end
            if (drop_inc && drop_q != 16'hFFFF) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tag_latch) begin
            lat_tag <= stu__rtr__tag;
        end
    end

    assign rtr__sys__proto_err  = proto_err_q;
    assign rtr__sys__drop_count = drop_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
        logic [ENT_W-1:0] mem [FIFO_DEPTH];
        logic [AW:0]      wr_ptr, rd_ptr;
        logic [ENT_W-1:0] head;

        assign push[g]  = push_any && (push_ch == CH_W'(g));
        assign empty[g] = (wr_ptr == rd_ptr);
        assign full[g]  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        assign pop[g]   = rtr__cns__valid[g] && cns__rtr__ready[g];

        always_ff @(posedge clk) begin
            if (reset_poweron) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push[g]) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop[g]) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (push[g]) begin
                mem[wr_ptr[AW-1:0]] <= {push_cntl, push_tag, stu__rtr__data};
            end
        end

        assign head                             = mem[rd_ptr[AW-1:0]];
        assign rtr__cns__valid[g]               = !empty[g] && !reset_poweron;
        assign rtr__cns__cntl[2*g +: 2]         = head[ENT_W-1 -: 2];
        assign rtr__cns__tag[TAG_W*g +: TAG_W]  = head[DATA_W +: TAG_W];
        assign rtr__cns__data[DATA_W*g +: DATA_W] = head[DATA_W-1:0];
    end

endmodule

// File: tb/tb_mgr_upstream_router.sv
// Testbench for mgr_upstream_router: directed scenarios followed by random
// traffic, all compared each cycle against a packet-level reference model
// built from per-channel queues.
module tb_mgr_upstream_router;

    localparam int NUM_CH     = 4;
    localparam int DATA_W     = 64;
    localparam int TAG_W      = 8;
    localparam int FIFO_DEPTH = 8;

    localparam logic [1:0] SOM_EOM = 2'b00;
    localparam logic [1:0] SOM     = 2'b01;
    localparam logic [1:0] MOM     = 2'b10;
    localparam logic [1:0] EOM     = 2'b11;

    logic                     clk = 1'b0;
    logic                     reset_poweron;
    logic                     in_valid;
    logic [1:0]               in_cntl;
    logic                     rdy;
    logic [TAG_W-1:0]         in_tag;
    logic [DATA_W-1:0]        in_data;
    logic [NUM_CH-1:0]        out_valid;
    logic [2*NUM_CH-1:0]      out_cntl;
    logic [NUM_CH-1:0]        out_ready;
    logic [TAG_W*NUM_CH-1:0]  out_tag;
    logic [DATA_W*NUM_CH-1:0] out_data;
    logic [NUM_CH-1:0]        ch_enable;
    logic                     err_clear;
    logic                     proto_err;
    logic [15:0]              drop_count;

    always #5 clk = ~clk;

    mgr_upstream_router #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .TAG_W(TAG_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk                 (clk),
        .reset_poweron       (reset_poweron),
        .stu__rtr__valid     (in_valid),
        .stu__rtr__cntl      (in_cntl),
        .rtr__stu__ready     (rdy),
        .stu__rtr__tag       (in_tag),
        .stu__rtr__data      (in_data),
        .rtr__cns__valid     (out_valid),
        .rtr__cns__cntl      (out_cntl),
        .cns__rtr__ready     (out_ready),
        .rtr__cns__tag       (out_tag),
        .rtr__cns__data      (out_data),
        .cfg__rtr__ch_enable (ch_enable),
        .cfg__rtr__err_clear (err_clear),
        .rtr__sys__proto_err (proto_err),
        .rtr__sys__drop_count(drop_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Reference model: one queue of expected beats per channel plus the
    // context of the packet currently arriving.
    typedef struct packed {
        logic [1:0]        c;
        logic [TAG_W-1:0]  t;
        logic [DATA_W-1:0] d;
    } beat_t;

    beat_t            mq [NUM_CH][$];
    int               m_mode = 0;   // 0 between packets, 1 forwarding, 2 discarding
    int               m_ch   = 0;
    logic [TAG_W-1:0] m_tag  = '0;
    logic             m_err  = 1'b0;
    int               m_drops = 0;

    function automatic int tag_to_ch(input logic [TAG_W-1:0] t);
        return int'(t) % (1 << $clog2(NUM_CH));
    endfunction

    task automatic step(input logic v, input logic [1:0] c, input logic [TAG_W-1:0] t,
                        input logic [DATA_W-1:0] d, input logic [NUM_CH-1:0] cr,
                        input logic [NUM_CH-1:0] en, input logic clr, input logic rst,
                        output logic acc);
        logic              exp_rdy;
        logic [NUM_CH-1:0] exp_vld;
        logic              new_err;
        logic [1:0]        ec;
        beat_t             b;
        int                ch;
        @(negedge clk);
        reset_poweron = rst;
        in_valid      = v;
        in_cntl       = c;
        in_tag        = t;
        in_data       = d;
        out_ready     = cr;
        ch_enable     = en;
        err_clear     = clr;
        #1;
        ch = tag_to_ch(t);
        if (rst) exp_rdy = 1'b0;
        else if (m_mode == 0) begin
            if ((c == SOM_EOM || c == SOM) && ch < NUM_CH && en[ch]) exp_rdy = (mq[ch].size() < FIFO_DEPTH);
            else exp_rdy = 1'b1;
        end
        else if (m_mode == 1) exp_rdy = (mq[m_ch].size() < FIFO_DEPTH);
        else exp_rdy = 1'b1;
        for (int i = 0; i < NUM_CH; i++) exp_vld[i] = !rst && (mq[i].size() > 0);

        check_val("ready", rdy, exp_rdy);
        check_val("valid", out_valid, exp_vld);
        for (int i = 0; i < NUM_CH; i++) begin
            if (exp_vld[i] && out_valid[i]) begin
                b = mq[i][0];
                check_val($sformatf("head_ch%0d", i),
                          {out_cntl[2*i +: 2], out_tag[TAG_W*i +: TAG_W], out_data[DATA_W*i +: DATA_W]}, b);
            end
        end
        check_val("proto_err", proto_err, m_err);
        check_val("drop_count", drop_count, 16'(m_drops));

        acc = v && exp_rdy;
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) mq[i].delete();
            m_mode  = 0;
            m_err   = 1'b0;
            m_drops = 0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cr[i] && mq[i].size() > 0) void'(mq[i].pop_front());
            end
            new_err = 1'b0;
            if (acc) begin
                if (m_mode == 0) begin
                    if (c == MOM || c == EOM) new_err = 1'b1;
                    else if (ch < NUM_CH && en[ch]) begin
                        b.c = c; b.t = t; b.d = d;
                        mq[ch].push_back(b);
                        if (c == SOM) begin m_mode = 1; m_ch = ch; m_tag = t; end
                    end else begin
                        if (m_drops < 16'hFFFF) m_drops++;
                        if (c == SOM) m_mode = 2;
                    end
                end else begin
                    ec = c;
                    if (c == SOM)     begin ec = MOM; new_err = 1'b1; end
                    if (c == SOM_EOM) begin ec = EOM; new_err = 1'b1; end
                    if (m_mode == 1) begin
                        b.c = ec; b.t = m_tag; b.d = d;
                        mq[m_ch].push_back(b);
                    end
                    if (ec == EOM) m_mode = 0;
                end
            end
            if (new_err) m_err = 1'b1;
            else if (clr) m_err = 1'b0;
        end
    endtask

    task automatic send(input logic [1:0] c, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d,
                        input logic [NUM_CH-1:0] cr, input logic [NUM_CH-1:0] en);
        logic acc;
        int   n = 0;
        do begin
            step(1'b1, c, t, d, cr, en, 1'b0, 1'b0, acc);
            n++;
        end while (!acc && n < 50);
        check_val("send_accepted", acc, 1'b1);
    endtask

    task automatic idle(input int n, input logic [NUM_CH-1:0] cr, input logic [NUM_CH-1:0] en);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, MOM, '0, '0, cr, en, 1'b0, 1'b0, acc);
    endtask

    initial begin
        logic              acc;
        logic [1:0]        cc;
        logic [NUM_CH-1:0] en_r, cr_r;
        int                k;

        reset_poweron = 1'b1;
        in_valid = 1'b0; in_cntl = MOM; in_tag = '0; in_data = '0;
        out_ready = '0; ch_enable = '1; err_clear = 1'b0;
        repeat (2) @(posedge clk);
        step(1'b1, SOM, 8'h01, 64'h1, 4'hF, 4'hF, 1'b0, 1'b1, acc);
        step(1'b0, MOM, 8'h00, 64'h0, 4'hF, 4'hF, 1'b0, 1'b1, acc);
        check_val("reset_ready", rdy, 1'b0);
        check_val("reset_valid", out_valid, 4'b0000);

        // Single-beat packet to ch2
        send(SOM_EOM, 8'h02, 64'hA5, 4'h0, 4'hF);
        idle(1, 4'h0, 4'hF);
        check_val("single_valid", out_valid, 4'b0100);
        check_val("single_cntl", out_cntl[5:4], SOM_EOM);
        check_val("single_tag", out_tag[23:16], 8'h02);
        check_val("single_data", out_data[191:128], 64'hA5);
        idle(4, 4'hF, 4'hF);

        // 10-beat packet to stalled ch1
        k = 0;
        for (int cyc = 0; cyc < 40 && k < 10; cyc++) begin
            cr_r = (cyc >= 12) ? 4'hF : 4'h0;
            cc   = (k == 0) ? SOM : ((k == 9) ? EOM : MOM);
            step(1'b1, cc, (k == 0) ? 8'h01 : 8'($urandom), 64'(100 + k), cr_r, 4'hF, 1'b0, 1'b0, acc);
            if (cyc == 11) begin
                check_val("bp_ready_low", rdy, 1'b0);
                check_val("bp_accepted", k, 8);
            end
            if (acc) k++;
        end
        check_val("bp_all_accepted", k, 10);
        idle(15, 4'hF, 4'hF);

        // Dropped packet to disabled ch1, then dropped single beat
        send(SOM, 8'h05, 64'h1, 4'hF, 4'b1101);
        send(MOM, 8'h05, 64'h2, 4'hF, 4'b1101);
        send(EOM, 8'h05, 64'h3, 4'hF, 4'b1101);
        idle(1, 4'hF, 4'b1101);
        check_val("drop_one", drop_count, 16'd1);
        send(SOM_EOM, 8'h01, 64'h4, 4'hF, 4'b1101);
        idle(1, 4'hF, 4'b1101);
        check_val("drop_two", drop_count, 16'd2);

        // Protocol error: MOM in idle, clear racing a new error, lone clear
        send(MOM, 8'h00, 64'h9, 4'hF, 4'hF);
        idle(1, 4'hF, 4'hF);
        check_val("perr_set", proto_err, 1'b1);
        step(1'b1, MOM, 8'h00, 64'h9, 4'hF, 4'hF, 1'b1, 1'b0, acc);
        idle(1, 4'hF, 4'hF);
        check_val("perr_set_wins", proto_err, 1'b1);
        step(1'b0, MOM, 8'h00, 64'h0, 4'hF, 4'hF, 1'b1, 1'b0, acc);
        idle(1, 4'hF, 4'hF);
        check_val("perr_cleared", proto_err, 1'b0);

        // Fill stalled ch0, route a packet to ch3, then pop with blocked push
        for (int i = 0; i < FIFO_DEPTH; i++) send(SOM_EOM, 8'h00, 64'(200 + i), 4'h0, 4'hF);
        send(SOM, 8'h03, 64'h31, 4'h0, 4'hF);
        send(MOM, 8'h03, 64'h32, 4'h0, 4'hF);
        send(EOM, 8'h03, 64'h33, 4'h0, 4'hF);
        idle(1, 4'h0, 4'hF);
        check_val("il_ch0_full_valid", out_valid, 4'b1001);
        step(1'b1, SOM_EOM, 8'h00, 64'hBEEF, 4'b0001, 4'hF, 1'b0, 1'b0, acc);
        check_val("il_blocked_push", rdy, 1'b0);
        send(SOM_EOM, 8'h00, 64'hBEEF, 4'b0000, 4'hF);
        idle(20, 4'hF, 4'hF);

        // Reset in the middle of a packet
        send(SOM, 8'h02, 64'h51, 4'h0, 4'hF);
        send(MOM, 8'h02, 64'h52, 4'h0, 4'hF);
        step(1'b0, MOM, 8'h00, 64'h0, 4'h0, 4'hF, 1'b0, 1'b1, acc);
        idle(1, 4'h0, 4'hF);
        check_val("mid_rst_valid", out_valid, 4'b0000);
        send(EOM, 8'h02, 64'h53, 4'h0, 4'hF);
        idle(1, 4'h0, 4'hF);
        check_val("mid_rst_perr", proto_err, 1'b1);
        step(1'b0, MOM, 8'h00, 64'h0, 4'hF, 4'hF, 1'b1, 1'b0, acc);

        // Random traffic
        en_r = 4'hF;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if ($urandom_range(0, 49) == 0) en_r = ($urandom_range(0, 2) == 0) ? 4'(($urandom)) : 4'hF;
            for (int i = 0; i < NUM_CH; i++) cr_r[i] = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 99) < 8) cc = 2'($urandom);
            else if (m_mode == 0) cc = ($urandom_range(0, 1) == 0) ? SOM_EOM : SOM;
            else cc = ($urandom_range(0, 9) < 3) ? EOM : MOM;
            step($urandom_range(0, 9) < 7, cc, 8'($urandom), {$urandom, $urandom}, cr_r, en_r,
                 $urandom_range(0, 99) < 3, $urandom_range(0, 199) == 0, acc);
        end
        idle(20, 4'hF, 4'hF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mgr_upstream_router.md
MGR_UPSTREAM_ROUTER -- requirements
Module: mgr_upstream_router

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, the number of upstream consumer channels (2..8).
REQ-002 SHALL have parameter DATA_W, default 64, the upstream data width.
REQ-003 SHALL have parameter TAG_W, default 8, the upstream tag width; TAG_W >= CH_W, where CH_W = clog2(NUM_CH).
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, the per-channel entries; a power of 2, >= 2.
REQ-005 SHALL be clocked by clk; one clock; reset is synchronous and active-high.
REQ-006 Ports, in order: name, direction, width, meaning.
- clk  in  1  clock.
- reset_poweron  in  1  synchronous active-high reset.
- stu__rtr__valid  in  1  upstream beat valid.
- stu__rtr__cntl  in  2  delineator: 00 SOM_EOM, 01 SOM, 10 MOM, 11 EOM.
- rtr__stu__ready  out  1  beat accepted when valid&ready.
- stu__rtr__tag  in  TAG_W  packet tag.
- stu__rtr__data  in  DATA_W  beat data.
- rtr__cns__valid  out  NUM_CH  per-channel beat valid.
- rtr__cns__cntl  out  2*NUM_CH  per-channel delineator.
- cns__rtr__ready  in  NUM_CH  per-channel consumer ready.
- rtr__cns__tag  out  TAG_W*NUM_CH  per-channel tag.
- rtr__cns__data  out  DATA_W*NUM_CH  per-channel data.
- cfg__rtr__ch_enable  in  NUM_CH  a channel bit of 0 drops its packets.
- cfg__rtr__err_clear  in  1  clears the sticky error.
- rtr__sys__proto_err  out  1  sticky protocol error.
- rtr__sys__drop_count  out  16  count of dropped packets, saturating.

Function
REQ-007 Channel select ch = stu__rtr__tag[CH_W-1:0]; a value >= NUM_CH SHALL be treated as disabled.
REQ-008 FSM states: IDLE, ROUTE, DROP.
- IDLE: an accepted SOM goes to ROUTE (ch enabled) or DROP (disabled), and the channel is latched.
- IDLE: an accepted SOM_EOM is routed or dropped and the FSM stays in IDLE.
REQ-009 ROUTE/DROP: every beat SHALL go to the latched channel (or be discarded in DROP); an accepted EOM or SOM_EOM returns the FSM to IDLE.
REQ-010 rtr__stu__ready:
- IDLE, beat is SOM/SOM_EOM, ch enabled: ready = !full[ch].
- IDLE, other cases: ready = 1.
- ROUTE: ready = !full[latched].
- DROP: ready = 1.
- Ready may depend on tag/cntl; it SHALL NOT depend on stu__rtr__valid.
REQ-011 Each channel SHALL have a FIFO holding {cntl, tag, data}; pushed on an accepted routed beat. The tag stored for every beat is the tag latched at SOM.
REQ-012 Latency: a beat accepted at edge N SHALL be visible on rtr__cns__valid after edge N (no combinational bypass).
REQ-013 rtr__cns__valid[i] = !empty[i]; a pop occurs on valid&ready; the outputs present the FIFO head.
REQ-014 Full FIFO with a simultaneous pop: push SHALL NOT occur that cycle (ready is based on registered full only).
REQ-015 Pointers SHALL wrap modulo FIFO_DEPTH, with an extra wrap bit distinguishing full from empty; occupancy SHALL never exceed FIFO_DEPTH.
REQ-016 In IDLE, an accepted MOM/EOM SHALL be discarded and proto_err set.
REQ-017 In ROUTE/DROP, an accepted SOM SHALL be handled as a MOM and set proto_err. An accepted SOM_EOM SHALL be handled as an EOM and set proto_err.
REQ-018 drop_count SHALL increment once per packet that enters DROP or is a dropped SOM_EOM; it saturates at 0xFFFF.
REQ-019 proto_err SHALL stay set until cfg__rtr__err_clear. If clear and a new error occur in the same cycle, set wins.
REQ-020 A change to ch_enable mid-packet SHALL NOT affect the current packet; it takes effect at the next SOM.
REQ-021 Channels SHALL be independent: a stalled consumer SHALL NOT block packets to other channels except while the input beat targets it.

Reset
REQ-022 On reset_poweron:
- FSM = IDLE; all FIFOs empty.
- rtr__cns__valid = 0; rtr__stu__ready = 0 while reset is asserted.
- proto_err = 0; drop_count = 0; the latched channel = 0.
REQ-023 Reset asserted mid-packet SHALL discard all buffered beats; the next beat after reset SHALL be interpreted in IDLE.

Verification
REQ-024 Single-beat packet: SOM_EOM, tag 0x02, data 0xA5, all enabled -> ch2 valid on the next cycle with cntl 00, tag 0x02, data 0xA5; other channels stay idle.
REQ-025 Backpressure, FIFO_DEPTH 8: a 10-beat packet to ch1 with cns ready[1]=0 -> exactly 8 accepted, ready low; after ready[1]=1 all 10 beats are delivered in order, tag constant.
REQ-026 Drop: ch_enable=4'b1101, 3-beat packet with tag 0x05 -> ready=1 for all beats, no ch1 valid, drop_count=1; the following SOM_EOM with tag 0x01 -> drop_count=2.
REQ-027 Protocol error: a MOM in IDLE -> discarded, proto_err=1; err_clear pulsed together with a second MOM in IDLE -> proto_err stays 1; a lone err_clear -> 0.
REQ-028 Interleave: ch0 stalled and full, then a packet to ch3 -> it routes while ch0 remains full; simultaneous pop and blocked push on ch0 -> occupancy drops by 1 and the beat is held.
REQ-029 Reset mid-packet: assert reset after 2 of 4 beats -> all valid=0, FIFOs empty; a following EOM -> proto_err=1.
